pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Drives PC enable, IF/ID hold/flush and ID/EX bubble insertion.
//  Detects load-use hazards, flushes on taken branch, and runs a host halt/single-step protocol.
//  Host access through the FIFO needs a drained, quiescent pipeline; this handshake provides it.
//  Sits beside the ID/EX pipeline register; ID/EX loads all-zero control on idex_bubble=1.
// PARAMETERS
//  REG_W        5   register-address width
//  DRAIN_CYCLES 3   bubble cycles after the last issue before halted (EX, MEM, WB)
//  CNT_W        16  width of stall_cnt
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  id_rs1      in   REG_W  ID-stage source reg 1
//  id_rs2      in   REG_W  ID-stage source reg 2
//  id_use_rs1  in   1      ID instruction reads rs1
//  id_use_rs2  in   1      ID instruction reads rs2
//  ex_wreg     in   REG_W  EX-stage destination reg
//  ex_memrd    in   1      EX instruction is a load
//  br_taken    in   1      EX-stage branch resolved taken
//  halt_req    in   1      host halt request, level
//  step_req    in   1      host single-step, 1-cycle pulse
//  pc_en       out  1      PC register load enable
//  ifid_en     out  1      IF/ID load enable
//  ifid_flush  out  1      IF/ID loads NOP
//  idex_bubble out  1      ID/EX loads zero control
//  halted      out  1      pipeline empty and frozen (registered)
//  stall_cnt   out  CNT_W  count of load-use stall cycles, saturating
// BEHAVIOUR
//  Reset (reset=0, async) forces:
//   state=RUN, cnt=0, halted=0, stall_cnt=0
//   pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1
//  pc_en / ifid_en / ifid_flush / idex_bubble are combinational from state and live inputs (0-cycle latency).
//  lu = ex_memrd & ex_wreg!=0 & ((id_use_rs1 & id_rs1==ex_wreg) | (id_use_rs2 & id_rs2==ex_wreg)).
//  States: RUN, ISSUE, DRAIN, HALTED, STEP.
//  RUN:
//   default pc_en=1, ifid_en=1, flush=0, bubble=0.
//   br_taken: pc_en=1, ifid_flush=1, idex_bubble=1. Overrides lu.
//   else lu: pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt+1 (saturates at all-ones).
//   halt_req & !lu & !br_taken -> ISSUE. Otherwise the halt is deferred and halt_req is re-sampled next cycle.
//  ISSUE (the ID instruction issues; no new fetch):
//   pc_en=0, ifid_flush=1, bubble=0 -> DRAIN, cnt=0.
//   if lu: stall as in RUN (pc_en=0, ifid_en=0, bubble=1, stall_cnt+1) and stay in ISSUE.
//   br_taken in ISSUE: pc_en=1 (PC loads target), flush and bubble as in RUN, -> DRAIN.
//  DRAIN:
//   pc_en=0, ifid_flush=1, idex_bubble=1; cnt+1.
//   br_taken: pc_en=1 so the PC captures the target; no other change.
//   cnt==DRAIN_CYCLES-1 -> HALTED; halted=1 from the next edge.
//  HALTED:
//   pc_en=0, ifid_en=0, flush=0, bubble=1.
//   !halt_req -> RUN; halted=0 from the next edge.
//   else step_req -> STEP.
//   step_req outside HALTED is ignored.
//  STEP:
//   pc_en=1, ifid_en=1, bubble=1, halted=0 -> ISSUE.
//   Exactly one instruction is fetched, issued, drained, then halted re-asserts.
//  halt_req dropped in ISSUE/DRAIN/STEP: the sequence still completes to HALTED, then exits to RUN.
//  Reset mid-sequence: immediate return to reset values. The PC is not advanced during reset.
// STRUCTURE
//  Package pipe_ctrl_pkg:
//   state encoding localparams (RUN, ISSUE, DRAIN, HALTED, STEP)
//   DRAIN_CYCLES default
//   REG_W
//  Sub-module hazard_cmp: combinational lu detect; reused later for forwarding-mux select.
//  Top level: state register, drain counter, stall counter, output decode.
// TESTING
//  T1 RUN, ex_memrd=1, ex_wreg=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt 0->1.
//  T2 As T1 but ex_wreg=0, or id_use_rs1=0 -> no stall, pc_en=1, stall_cnt unchanged.
//  T3 lu and br_taken same cycle -> pc_en=1, ifid_flush=1, idex_bubble=1; stall_cnt unchanged.
//  T4 halt_req=1 held in RUN, no hazard:
//     cycle0 ISSUE (bubble=0), cycles1-3 DRAIN (bubble=1), halted=1 after edge 4.
//     Drop halt_req -> RUN, pc_en=1 next cycle.
//  T5 HALTED, step_req pulse:
//     1 cycle pc_en=1, then ISSUE, 3 DRAIN, halted re-asserts after 5 edges.
//     Exactly one pc_en=1 in the window.
//  T6 reset=0 asserted in DRAIN cnt=1, stall_cnt=7 -> same-cycle halted=0, stall_cnt=0, idex_bubble=1; after release, RUN.
//  T7 stall_cnt preset near all-ones + repeated lu -> holds at all-ones, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, default
// widths/depths and the per-cycle pipeline control bundle.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W_DEF        = 5;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned CNT_W_DEF        = 16;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_RUN    = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE  = 3'd1;
  localparam logic [ST_W-1:0] ST_DRAIN  = 3'd2;
  localparam logic [ST_W-1:0] ST_HALTED = 3'd3;
  localparam logic [ST_W-1:0] ST_STEP   = 3'd4;

  // Control applied to the front of the pipe in a given cycle.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctl_t;

  function automatic pipe_ctl_t mk_ctl(input logic pc_en, input logic ifid_en,
                                       input logic ifid_flush, input logic idex_bubble);
    pipe_ctl_t c;
    c.pc_en       = pc_en;
    c.ifid_en     = ifid_en;
    c.ifid_flush  = ifid_flush;
    c.idex_bubble = idex_bubble;
    return c;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load
// destination. Register 0 is hard-wired zero and never creates a hazard.
// Ports:
//   rs1, rs2         ID-stage source registers
//   use_rs1, use_rs2 ID instruction actually reads the source
//   wreg             EX-stage destination register
//   memrd            EX instruction is a load
//   lu_c             load-use hazard (combinational)
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [REG_W-1:0] wreg,
  input  logic             memrd,
  output logic             lu_c
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1 = use_rs1 && (rs1 == wreg);
    hit_rs2 = use_rs2 && (rs2 == wreg);
    lu_c    = memrd && (wreg != '0) && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes and a host halt / single-step handshake that leaves the pipeline
// drained and frozen.
// Ports:
//   clk, reset                     clock and async active-low reset
//   id_rs1/id_rs2/id_use_rs1/2     ID-stage operand usage
//   ex_wreg/ex_memrd               EX-stage load destination
//   br_taken                       EX-stage branch resolved taken
//   halt_req/step_req              host halt (level) / single-step (pulse)
//   pc_en/ifid_en/ifid_flush/idex_bubble  pipe control, combinational
//   halted                         pipeline empty and frozen (registered)
//   stall_cnt                      saturating load-use stall cycle count
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_memrd,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

  logic              lu_c;
  logic [ST_W-1:0]   state_q;
  logic [ST_W-1:0]   state_nxt;
  logic [DCNT_W-1:0] cnt_q;
  logic [DCNT_W-1:0] cnt_nxt;
  logic              stall_inc;
  pipe_ctl_t         ctl;

  hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .wreg    (ex_wreg),
    .memrd   (ex_memrd),
    .lu_c    (lu_c)
  );

  // Next-state and pipe-control decode.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    stall_inc = 1'b0;
    ctl       = mk_ctl(1'b1, 1'b1, 1'b0, 1'b0);

    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          ctl = mk_ctl(1'b1, 1'b1, 1'b1, 1'b1);
        end else if (lu_c) begin
          ctl       = mk_ctl(1'b0, 1'b0, 1'b0, 1'b1);
          stall_inc = 1'b1;
        end else if (halt_req) begin
          state_nxt = ST_ISSUE;
        end
      end

      // Let the instruction in ID issue while fetch stops.
      ST_ISSUE: begin
        if (br_taken) begin
          ctl       = mk_ctl(1'b1, 1'b1, 1'b1, 1'b1);
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end else if (lu_c) begin
          ctl       = mk_ctl(1'b0, 1'b0, 1'b0, 1'b1);
          stall_inc = 1'b1;
        end else begin
          ctl       = mk_ctl(1'b0, 1'b1, 1'b1, 1'b0);
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end
      end

      // Bubbles push the last issued instruction through EX/MEM/WB; a late
      // branch still lets the PC capture its target.
      ST_DRAIN: begin
        ctl     = mk_ctl(br_taken, 1'b1, 1'b1, 1'b1);
        cnt_nxt = cnt_q + DCNT_W'(1);
        if (cnt_q == DCNT_LAST) begin
          state_nxt = ST_HALTED;
          cnt_nxt   = '0;
        end
      end

      ST_HALTED: begin
        ctl = mk_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        if (!halt_req) begin
          state_nxt = ST_RUN;
        end else if (step_req) begin
          state_nxt = ST_STEP;
        end
      end

      // Fetch exactly one instruction, then replay the issue/drain sequence.
      ST_STEP: begin
        ctl       = mk_ctl(1'b1, 1'b1, 1'b0, 1'b1);
        state_nxt = ST_ISSUE;
      end

      default: begin
        ctl       = mk_ctl(1'b0, 1'b0, 1'b1, 1'b1);
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase

    // Keep the PC frozen and the pipe flushed while reset is asserted.
    if (!reset) begin
      ctl = mk_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    end

    pc_en       = ctl.pc_en;
    ifid_en     = ctl.ifid_en;
    ifid_flush  = ctl.ifid_flush;
    idex_bubble = ctl.idex_bubble;
  end

  // State, drain counter and halted flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      halted  <= (state_nxt == ST_HALTED);
    end
  end

  // Saturating load-use stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
